// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
// Module   : fifo_wr_arbiter_pkg
// Brief    : Shared state encoding and grant-index width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Grant index width; a single-bit index is kept even for degenerate sizes.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search starting just above last_ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin : p_pick
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              granted;
    logic              accept;
    logic              last_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req      (req_valid),
        .last_ptr (last_ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign granted   = (state_q == ST_GRANT);
    assign accept    = granted && req_valid[grant_id_q] && !fifo_full;
    assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                // A full FIFO with valid still high simply holds the grant.
                if (!req_valid[grant_id_q] || (accept && last_beat)) begin
                    state_d    = ST_IDLE;
                    last_ptr_d = grant_id_q;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_ptr_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign fifo_wr_en = accept;
    assign fifo_cs    = granted;
    assign busy       = granted;
    assign grant_id   = grant_id_q;
    assign fifo_data  = granted ? req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH]
                                : '0;

endmodule

`default_nettype wire
